// File: rtl/btn_pkg.sv
// Shared types and 12 MHz board defaults for the push-button input path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_t;

  // 10 ms settle window and 1 s long-press hold at a 12 MHz clock.
  localparam int STABLE_CYCLES_12MHZ = 120000;
  localparam int LONG_CYCLES_12MHZ   = 12000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin, with a configurable reset value.
// Latency: 2 CLK edges from pin to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic s1;

  // Metastability chain: only q is safe to use in the CLK domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces one raw button pin into a level, rise/fall pulses and a wrapping press count.
// Latency: STABLE_CYCLES+3 edges from pin step to level/pulse; optional long_press via BTN_DEBOUNCE_LONG_PRESS_EN.
// Backpressure: none; events are single-cycle pulses and are not held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int   STABLE_CYCLES = STABLE_CYCLES_12MHZ,
  parameter logic IDLE_LEVEL    = 1'b0,
  parameter int   PRESS_W       = 8
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int   LONG_CYCLES   = LONG_CYCLES_12MHZ
`endif
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               BTN,
  output logic               level,
  output logic               rise,
  output logic               fall,
  output logic [PRESS_W-1:0] presses
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  ,
  output logic               long_press
`endif
);

  // Settle counter width is derived from the window and is never overridden.
  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  logic             raw;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             settle_done;
  logic             take_rise;
  logic             take_fall;

  sync_2ff #(
    .RST_VAL(IDLE_LEVEL)
  ) u_sync (
    .CLK  (CLK),
    .RST_N(RST_N),
    .d    (BTN),
    .q    (s2)
  );

  // Window completes this edge: new value survived STABLE_CYCLES consecutive samples.
  assign settle_done = (state == SETTLING) && (s2 != raw) && (cnt == CNT_LAST);
  assign take_rise   = settle_done && ((s2 ^ IDLE_LEVEL) == 1'b1);
  assign take_fall   = settle_done && ((s2 ^ IDLE_LEVEL) == 1'b0);

  // Settle FSM; level and edge pulses are registered on the same edge raw flips.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= STABLE;
      cnt   <= '0;
      raw   <= IDLE_LEVEL;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= take_rise;
      fall <= take_fall;
      case (state)
        STABLE: begin
          if (s2 != raw) begin
            state <= SETTLING;
            cnt   <= '0;
          end
        end
        SETTLING: begin
          if (s2 == raw) begin
            // Bounced back before the window closed: forget the attempt.
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            raw   <= s2;
            level <= s2 ^ IDLE_LEVEL;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Press counter advances together with rise and wraps silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presses <= '0;
    end else if (take_rise) begin
      presses <= presses + PRESS_W'(1);
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int             HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              armed;

  // Hold timer: armed by a press, fires once, disarmed by the pulse or a release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt   <= '0;
      armed      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (take_fall) begin
        armed    <= 1'b0;
        hold_cnt <= '0;
      end else if (take_rise) begin
        armed    <= 1'b1;
        hold_cnt <= '0;
      end else if (armed && level) begin
        if (hold_cnt == HOLD_LAST) begin
          long_press <= 1'b1;
          armed      <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end
`endif

endmodule
